ifetch_unit32: RTL and testbench

//  Instruction fetch stage directly upstream of the main decoder. Holds the PC, addresses a synchronous

---
 rtl/ifetch_unit32.sv | 111 +++++++++++
 tb/tb_ifetch_unit32.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit32.sv
// Instruction fetch stage: PC register, sync-ROM addressing and next-PC resolution for the decoder.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
//
// state | meaning
// FILL  | first cycle after reset, ROM is reading RESET_PC, no valid instruction yet
// RUN   | Instruction valid every cycle, PC advances unless stalled
module ifetch_unit32 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_F000,
   parameter int          ROM_AW   = 14
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic [31:0]       Instruction,
   output logic              instr_valid,
   output logic [31:0]       pc_out,
   output logic [31:0]       opcplus4,
   input  logic              stall,
   input  logic              Branch,
   input  logic              nBranch,
   input  logic              Jmp,
   input  logic              Jal,
   input  logic              Jrn,
   input  logic              Zero,
   input  logic [31:0]       Sign_extend,
   input  logic [31:0]       Read_data_1,
   output logic              align_err,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_redirect
);

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_opcplus4;
   logic        r_align_err;

   logic [31:0] w_pc4;
   logic [31:0] w_next_pc;
   logic        w_consume;
   logic        w_misalign;

   assign w_pc4      = r_pc + 32'd4;
   assign w_consume  = (r_state == S_RUN) & ~stall;
   assign w_misalign = Read_data_1[1:0] != 2'b00;

   // Stall and FILL both hold the PC so the ROM re-reads the same word.
   always_comb begin
      w_next_pc = w_pc4;
      if (!w_consume)
         w_next_pc = r_pc;
      else if (Jrn && w_misalign)
         w_next_pc = TRAP_PC;
      else if (Jrn)
         w_next_pc = Read_data_1;
      else if (Jmp || Jal)
         w_next_pc = {w_pc4[31:28], rom_rdata[25:0], 2'b00};
      else if ((Branch && Zero) || (nBranch && !Zero))
         w_next_pc = w_pc4 + (Sign_extend << 2);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_FILL;
         r_pc        <= RESET_PC;
         r_opcplus4  <= 32'h0;
         r_align_err <= 1'b0;
      end else begin
         r_state <= S_RUN;
         r_pc    <= w_next_pc;
         if (w_consume && Jal && !Jrn)
            r_opcplus4 <= w_pc4;
         if (w_consume && Jrn && w_misalign)
            r_align_err <= 1'b1;
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] r_perf_retired;
   logic [31:0] r_perf_redirect;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_retired  <= 32'h0;
         r_perf_redirect <= 32'h0;
      end else if (w_consume) begin
         r_perf_retired <= r_perf_retired + 32'd1;
         if (w_next_pc != w_pc4)
            r_perf_redirect <= r_perf_redirect + 32'd1;
      end
   end

   assign perf_retired  = r_perf_retired;
   assign perf_redirect = r_perf_redirect;
`else
   assign perf_retired  = 32'h0;
   assign perf_redirect = 32'h0;
`endif

   assign rom_addr    = w_next_pc[ROM_AW+1:2];
   assign Instruction = rom_rdata;
   assign instr_valid = (r_state == S_RUN);
   assign pc_out      = r_pc;
   assign opcplus4    = r_opcplus4;
   assign align_err   = r_align_err;

endmodule

// File: tb/tb_ifetch_unit32.sv
// Directed testbench for ifetch_unit32 with a behavioural 16K-word synchronous ROM.
// Counter expectations follow IFETCH_PERF_EN when the bench is built with it.
module tb_ifetch_unit32;

   logic        clock;
   logic        reset_n;
   logic [13:0] rom_addr;
   logic [31:0] rom_rdata;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] opcplus4;
   logic        stall, Branch, nBranch, Jmp, Jal, Jrn, Zero;
   logic [31:0] Sign_extend;
   logic [31:0] Read_data_1;
   logic        align_err;
   logic [31:0] perf_retired;
   logic [31:0] perf_redirect;

   logic [31:0] mem [0:16383];
   int total = 0;
   int bad   = 0;

   ifetch_unit32 dut (
      .clock(clock), .reset_n(reset_n), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .Instruction(Instruction), .instr_valid(instr_valid), .pc_out(pc_out),
      .opcplus4(opcplus4), .stall(stall), .Branch(Branch), .nBranch(nBranch),
      .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero), .Sign_extend(Sign_extend),
      .Read_data_1(Read_data_1), .align_err(align_err),
      .perf_retired(perf_retired), .perf_redirect(perf_redirect)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) rom_rdata <= mem[rom_addr];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ctrl();
      stall = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
      Sign_extend = 32'h0; Read_data_1 = 32'h0;
   endtask

   task automatic jump_to(input logic [31:0] tgt);
      clear_ctrl();
      Jrn = 1; Read_data_1 = tgt;
      step();
      clear_ctrl();
   endtask

   task automatic test_reset();
      clear_ctrl();
      reset_n = 0;
      repeat (3) step();
      total++; if (rom_addr !== 14'h0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
      total++; if (opcplus4 !== 32'h0 || align_err !== 1'b0) begin bad++; $display("FAIL reset_regs opc=%h ae=%b exp=0/0", opcplus4, align_err); end
      reset_n = 1;
      #1;
      total++; if (instr_valid !== 1'b0 || pc_out !== 32'h0) begin bad++; $display("FAIL fill_cycle valid=%b pc=%h exp=0/0", instr_valid, pc_out); end
      step();
      total++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || Instruction !== 32'h0) begin bad++; $display("FAIL run0 valid=%b pc=%h ins=%h exp=1/0/0", instr_valid, pc_out, Instruction); end
      step();
      total++; if (pc_out !== 32'h4 || Instruction !== 32'h1) begin bad++; $display("FAIL run1 pc=%h ins=%h exp=4/1", pc_out, Instruction); end
      step();
      total++; if (pc_out !== 32'h8 || Instruction !== 32'h2) begin bad++; $display("FAIL run2 pc=%h ins=%h exp=8/2", pc_out, Instruction); end
   endtask

   task automatic test_branch();
      jump_to(32'h40);
      total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL br_setup pc=%h exp=40", pc_out); end
      Branch = 1; Zero = 1; Sign_extend = 32'hFFFF_FFFE;
      step();
      total++; if (pc_out !== 32'h3C || Instruction !== 32'hF) begin bad++; $display("FAIL beq_taken pc=%h ins=%h exp=3c/f", pc_out, Instruction); end
      jump_to(32'h40);
      Branch = 1; Zero = 0; Sign_extend = 32'hFFFF_FFFE;
      step();
      total++; if (pc_out !== 32'h44) begin bad++; $display("FAIL beq_not_taken pc=%h exp=44", pc_out); end
      jump_to(32'h40);
      nBranch = 1; Zero = 0; Sign_extend = 32'hFFFF_FFFE;
      step();
      total++; if (pc_out !== 32'h3C) begin bad++; $display("FAIL bne_taken pc=%h exp=3c", pc_out); end
      clear_ctrl();
   endtask

   task automatic test_jal();
      jump_to(32'h1000_0010);
      total++; if (Instruction !== 32'h0C00_0100) begin bad++; $display("FAIL jal_fetch ins=%h exp=0c000100", Instruction); end
      Jal = 1;
      step();
      clear_ctrl();
      total++; if (pc_out !== 32'h1000_0400) begin bad++; $display("FAIL jal_target pc=%h exp=10000400", pc_out); end
      total++; if (opcplus4 !== 32'h1000_0014) begin bad++; $display("FAIL jal_link opc=%h exp=10000014", opcplus4); end
      Jmp = 1;
      step();
      clear_ctrl();
      total++; if (pc_out !== 32'h1000_0400 || opcplus4 !== 32'h1000_0014) begin bad++; $display("FAIL jmp_self pc=%h opc=%h exp=10000400/10000014", pc_out, opcplus4); end
   endtask

   task automatic test_jrn();
      jump_to(32'h0000_0202);
      total++; if (pc_out !== 32'h0000_F000 || align_err !== 1'b1) begin bad++; $display("FAIL jr_trap pc=%h ae=%b exp=f000/1", pc_out, align_err); end
      jump_to(32'h0000_0200);
      total++; if (pc_out !== 32'h0000_0200 || align_err !== 1'b1) begin bad++; $display("FAIL jr_ok pc=%h ae=%b exp=200/1", pc_out, align_err); end
      Jrn = 1; Read_data_1 = 32'h300; Jal = 1; Branch = 1; Zero = 1;
      step();
      clear_ctrl();
      total++; if (pc_out !== 32'h300 || opcplus4 !== 32'h1000_0014) begin bad++; $display("FAIL jr_priority pc=%h opc=%h exp=300/10000014", pc_out, opcplus4); end
   endtask

   task automatic test_wrap();
      jump_to(32'hFFFF_FFFC);
      total++; if (pc_out !== 32'hFFFF_FFFC || Instruction !== 32'h3FFF) begin bad++; $display("FAIL wrap_top pc=%h ins=%h exp=fffffffc/3fff", pc_out, Instruction); end
      step();
      total++; if (pc_out !== 32'h0 || Instruction !== 32'h0) begin bad++; $display("FAIL wrap_zero pc=%h ins=%h exp=0/0", pc_out, Instruction); end
   endtask

   task automatic test_stall();
      jump_to(32'h200);
      stall = 1; Branch = 1; Zero = 1; Sign_extend = 32'h4;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (pc_out !== 32'h200 || Instruction !== 32'h80 || rom_addr !== 14'h80) begin bad++; $display("FAIL stall_hold%0d pc=%h ins=%h ra=%h exp=200/80/80", i, pc_out, Instruction, rom_addr); end
      end
      stall = 0;
      step();
      clear_ctrl();
      total++; if (pc_out !== 32'h214) begin bad++; $display("FAIL stall_release pc=%h exp=214", pc_out); end
      step();
      total++; if (pc_out !== 32'h218) begin bad++; $display("FAIL after_release pc=%h exp=218", pc_out); end
      reset_n = 0;
      #1;
      total++; if (pc_out !== 32'h0 || instr_valid !== 1'b0 || rom_addr !== 14'h0) begin bad++; $display("FAIL midrun_reset pc=%h v=%b ra=%h exp=0/0/0", pc_out, instr_valid, rom_addr); end
      total++; if (align_err !== 1'b0 || opcplus4 !== 32'h0 || perf_retired !== 32'h0 || perf_redirect !== 32'h0) begin bad++; $display("FAIL midrun_reset_regs ae=%b opc=%h pr=%h pd=%h exp=0", align_err, opcplus4, perf_retired, perf_redirect); end
      step();
      reset_n = 1;
   endtask

   task automatic test_perf();
      logic [31:0] exp_ret, exp_red;
`ifdef IFETCH_PERF_EN
      exp_ret = 32'd12; exp_red = 32'd2;
`else
      exp_ret = 32'd0;  exp_red = 32'd0;
`endif
      clear_ctrl();
      step();
      stall = 1;
      repeat (3) step();
      total++; if (perf_retired !== 32'h0 || perf_redirect !== 32'h0) begin bad++; $display("FAIL perf_stall_frozen ret=%h red=%h exp=0/0", perf_retired, perf_redirect); end
      stall = 0;
      repeat (10) step();
      Branch = 1; Zero = 1; Sign_extend = 32'h2;
      repeat (2) step();
      clear_ctrl();
      total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL perf_pc got=%h exp=40", pc_out); end
      total++; if (perf_retired !== exp_ret) begin bad++; $display("FAIL perf_retired got=%0d exp=%0d", perf_retired, exp_ret); end
      total++; if (perf_redirect !== exp_red) begin bad++; $display("FAIL perf_redirect got=%0d exp=%0d", perf_redirect, exp_red); end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = i;
      mem[4] = 32'h0C00_0100;
      rom_rdata = 32'h0;
      test_reset();
      test_branch();
      test_jal();
      test_jrn();
      test_wrap();
      test_stall();
      test_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
